downscale_writer: RTL
=====================

# downscale_writer

Camera-side frame-buffer writer: consumes a raster pixel stream, decimates it by the selected integer scale factor, and emits write-port transactions into the 240×320 frame-buffer BRAM. It is the write-end counterpart to the display-side upscaler, which replicates each stored pixel N times. This block keeps one pixel in N along each axis so a 240N×320N source fills the buffer exactly. It sits between the camera pixel-reconstruction stage and port A of the frame-buffer BRAM.

## Interface
- DST_WIDTH, 240, frame-buffer columns
- DST_HEIGHT, 320, frame-buffer rows
- DATA_WIDTH, 16, pixel width (RGB565)
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- scale_in  input  2  decimation select: 0→1, 1→2, 2 or 3→4; sampled only on an accepted sof
- pixel_valid_in  input  1  qualifies pixel_data_in, sof_in, eol_in
- pixel_data_in  input  DATA_WIDTH  source pixel
- sof_in  input  1  first pixel of a frame (ignored unless pixel_valid_in)
- eol_in  input  1  last pixel of a line (ignored unless pixel_valid_in)
- wr_en_out  output  1  write strobe
- wr_addr_out  output  $clog2(DST_WIDTH*DST_HEIGHT) (17)  row-major address y*DST_WIDTH+x
- wr_data_out  output  DATA_WIDTH  pixel to write
- frame_done_out  output  1  one-cycle pulse when the buffer is completely written

## Operation
- States: IDLE (wait for sof), RUN (writing), FULL (DST_HEIGHT rows written; discard until next sof).
- Reset → IDLE. All outputs are 0 on reset.
- Accepted sof, from any state: latch N from scale_in and clear all counters. That pixel is processed as pixel (0,0) in RUN.
- A sof arriving in RUN aborts the partial frame and restarts at (0,0). No frame_done pulse is generated.
- Counters:
  - x_phase, y_phase: 0..N-1.
  - dst_x: 0..DST_WIDTH, saturates.
  - dst_y: 0..DST_HEIGHT.
  - line_base: running dst_y*DST_WIDTH, maintained by an adder. No multiplier.
- A pixel is kept iff state is RUN, x_phase==0, y_phase==0 and dst_x<DST_WIDTH. A kept pixel writes at address line_base+dst_x.
- Each valid pixel advances x_phase. dst_x increments when x_phase wraps to 0. Pixels past column DST_WIDTH*N are dropped (crop).
- Valid pixel with eol, after processing that pixel:
  - Clear x_phase and dst_x, and advance y_phase.
  - On the y_phase wrap of a kept row: dst_y+1 and line_base+DST_WIDTH.
  - If dst_y reaches DST_HEIGHT → FULL, and pulse frame_done_out.
- sof and eol in the same cycle: a one-pixel line. Write (0,0), then advance the row.
- A line shorter than DST_WIDTH*N leaves the remaining columns unwritten. There is no padding.
- scale_in changes mid-frame have no effect until the next sof.
- Cycles with pixel_valid_in low change no state.

## Timing
- Latency: exactly one cycle from pixel_valid_in to wr_en_out/wr_addr_out/wr_data_out. All outputs are registered.
- wr_en_out is high for exactly one cycle per kept pixel. Back-to-back writes are possible when N=1.
- No backpressure: the BRAM port accepts every cycle.
- frame_done_out is high in the same cycle as the final write of row DST_HEIGHT-1, i.e. one cycle after that row's eol.
- Reset asserted mid-frame: in the next cycle all outputs are 0 and the state is IDLE. Pixels are ignored until sof.
- wr_addr_out and wr_data_out hold their last value when wr_en_out is low.

## Structure
- The shared video package holds:
  - FB_WIDTH and FB_HEIGHT constants
  - the FB_ADDR_W constant
  - the scale-code → factor function (also used by the display-side upscaler)
  - the writer state enum
- One sub-module, decim_counter: a phase counter (mod N) plus a saturating output index with a wrap strobe. It is instantiated twice, once for the x axis and once for the y axis.

## Test plan
- N=1, 240×320 frame with data = address: 76800 writes at addresses 0..76799 in order. frame_done pulses once, coincident with the write to address 76799.
- scale_in=1, 480×640 frame: 76800 writes, keeping source (2i,2j) only. The source pixel at (4,2) lands at address 1*240+2=242. frame_done pulses once.
- scale_in=3 (treated as 4), 1000-pixel lines: columns beyond 960 are dropped. Each kept row has exactly 240 writes, with no address ≥ line_base+240.
- sof injected at row 10 of an N=1 frame: no frame_done pulse. The next write is at address 0, and 76800 further writes complete the frame.
- Reset asserted for one cycle mid-row: outputs are 0 in the following cycle. Pixels without sof produce no writes, and a subsequent sof restarts at address 0.
- Extra rows after FULL, and pixel_valid_in gaps of 1–5 cycles: no writes after frame_done. Gaps cause no address skips.

Source files
------------

// File: rtl/downscale_writer_pkg.sv
// Shared video definitions: frame-buffer geometry, scale-code decoding and
// the writer state encoding.
package downscale_writer_pkg;

    localparam int unsigned FB_WIDTH  = 240;
    localparam int unsigned FB_HEIGHT = 320;
    localparam int unsigned FB_ADDR_W = $clog2(FB_WIDTH * FB_HEIGHT);

    localparam int unsigned FACTOR_W = 3;
    localparam int unsigned PHASE_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FULL
    } wr_state_e;

    // Codes 2 and 3 both select x4.
    function automatic logic [FACTOR_W-1:0] scale_factor(input logic [1:0] code);
        case (code)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/downscale_writer_decim_counter.sv
// Mod-N phase counter with a saturating output index; restart clears before the
// current step is applied, flush clears after it.
module decim_counter
    import downscale_writer_pkg::*;
#(
    parameter  int unsigned MAX   = FB_WIDTH,
    localparam int unsigned IDX_W = $clog2(MAX + 1)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                restart_in,
    input  logic                step_in,
    input  logic                flush_in,
    input  logic [FACTOR_W-1:0] factor_in,
    output logic [PHASE_W-1:0]  phase_out,
    output logic [IDX_W-1:0]    idx_out,
    output logic                wrap_out
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FACTOR_W-1:0] last_phase;

    always_comb begin
        phase_out  = restart_in ? '0 : phase_q;
        idx_out    = restart_in ? '0 : idx_q;
        last_phase = factor_in - FACTOR_W'(1);
        wrap_out   = step_in && (FACTOR_W'(phase_out) == last_phase);
        phase_d    = phase_out;
        idx_d      = idx_out;
        if (flush_in) begin
            phase_d = '0;
            idx_d   = '0;
        end else if (step_in) begin
            if (wrap_out) begin
                phase_d = '0;
                if (idx_out < IDX_MAX) begin
                    idx_d = idx_out + IDX_W'(1);
                end
            end else begin
                phase_d = phase_out + PHASE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/downscale_writer.sv
// Decimating camera-side frame-buffer writer: keeps one pixel in N per axis and
// issues registered write-port transactions in row-major order.
module downscale_writer
    import downscale_writer_pkg::*;
#(
    parameter  int unsigned DST_WIDTH  = FB_WIDTH,
    parameter  int unsigned DST_HEIGHT = FB_HEIGHT,
    parameter  int unsigned DATA_WIDTH = 16,
    localparam int unsigned ADDR_W     = $clog2(DST_WIDTH * DST_HEIGHT)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [1:0]            scale_in,
    input  logic                  pixel_valid_in,
    input  logic [DATA_WIDTH-1:0] pixel_data_in,
    input  logic                  sof_in,
    input  logic                  eol_in,
    output logic                  wr_en_out,
    output logic [ADDR_W-1:0]     wr_addr_out,
    output logic [DATA_WIDTH-1:0] wr_data_out,
    output logic                  frame_done_out
);

    localparam int unsigned X_W = $clog2(DST_WIDTH + 1);
    localparam int unsigned Y_W = $clog2(DST_HEIGHT + 1);

    wr_state_e             state_q, state_d;
    logic [FACTOR_W-1:0]   factor_q, factor_d;
    logic [ADDR_W-1:0]     line_base_q, line_base_d, line_base_cur;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_done_q, frame_done_d;

    logic               sof_acc, run_now, keep, row_full;
    logic [PHASE_W-1:0] x_phase, y_phase;
    logic [X_W-1:0]     x_idx;
    logic [Y_W-1:0]     y_idx;
    logic               x_wrap_unused, y_wrap;

    // Front-end decode kept separate from the main comb block so the counter
    // outputs that depend on it do not form a combinational loop through it.
    assign sof_acc  = pixel_valid_in && sof_in;
    assign run_now  = pixel_valid_in && (sof_acc || state_q == ST_RUN);
    assign factor_d = sof_acc ? scale_factor(scale_in) : factor_q;

    decim_counter #(.MAX(DST_WIDTH)) u_x_cnt (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .restart_in (sof_acc),
        .step_in    (run_now),
        .flush_in   (run_now && eol_in),
        .factor_in  (factor_d),
        .phase_out  (x_phase),
        .idx_out    (x_idx),
        .wrap_out   (x_wrap_unused)
    );

    decim_counter #(.MAX(DST_HEIGHT)) u_y_cnt (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .restart_in (sof_acc),
        .step_in    (run_now && eol_in),
        .flush_in   (1'b0),
        .factor_in  (factor_d),
        .phase_out  (y_phase),
        .idx_out    (y_idx),
        .wrap_out   (y_wrap)
    );

    always_comb begin
        line_base_cur = sof_acc ? '0 : line_base_q;
        keep          = run_now && (x_phase == '0) && (y_phase == '0)
                        && (x_idx < X_W'(DST_WIDTH));
        row_full      = y_wrap && (y_idx == Y_W'(DST_HEIGHT - 1));

        state_d = state_q;
        if (row_full) begin
            state_d = ST_FULL;
        end else if (sof_acc) begin
            state_d = ST_RUN;
        end

        line_base_d = line_base_cur;
        if (y_wrap) begin
            line_base_d = line_base_cur + ADDR_W'(DST_WIDTH);
        end

        wr_en_d      = keep;
        wr_addr_d    = keep ? line_base_cur + ADDR_W'(x_idx) : wr_addr_q;
        wr_data_d    = keep ? pixel_data_in : wr_data_q;
        frame_done_d = row_full;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            factor_q     <= FACTOR_W'(1);
            line_base_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            factor_q     <= factor_d;
            line_base_q  <= line_base_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_en_out      = wr_en_q;
    assign wr_addr_out    = wr_addr_q;
    assign wr_data_out    = wr_data_q;
    assign frame_done_out = frame_done_q;

endmodule
